// File: rtl/stepmania_pkg.sv
// rtl/stepmania_pkg.sv - shared lane/arrow types and constants for the arrow scroller
package stepmania_pkg;

    localparam int NUM_LANES  = 4;
    localparam int ARROW_SIZE = 32;

    typedef logic [1:0] lane_t;
    typedef logic [9:0] arrow_y_t;

    // Number of set bits in a per-lane event vector
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - ordered per-lane arrow store with push, pop-head and move-all
module lane_fifo
    import stepmania_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int SPEED   = 2,
    parameter int SPAWN_Y = 448
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   dec,
    output arrow_y_t               head_y,
    output logic [DEPTH-1:0]       valid_mask,
    output arrow_y_t [DEPTH-1:0]   entry_y,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH + 1);

    arrow_y_t [DEPTH-1:0] y_q;
    arrow_y_t [DEPTH-1:0] y_d;
    arrow_y_t [DEPTH-1:0] moved;
    logic     [CW-1:0]    count_q;
    logic     [CW-1:0]    count_d;
    logic     [CW-1:0]    tail;

    assign head_y  = y_q[0];
    assign entry_y = y_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

    // Occupancy mask: entries below the count are live arrows
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = (CW'(i) < count_q);
        end
    end

    // Move existing arrows first, then shift out the head, then append the new
    // arrow so it keeps its spawn position on a move cycle
    always_comb begin
        moved = y_q;
        if (dec) begin
            for (int i = 0; i < DEPTH; i++) begin
                moved[i] = y_q[i] - arrow_y_t'(SPEED);
            end
        end
        y_d  = moved;
        tail = count_q;
        if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                y_d[i] = moved[i + 1];
            end
            y_d[DEPTH-1] = moved[DEPTH-1];
            tail = count_q - 1'b1;
        end
        count_d = tail;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == tail) begin
                    y_d[i] = arrow_y_t'(SPAWN_Y);
                end
            end
            count_d = tail + 1'b1;
        end
    end

    // Entry storage and occupancy count
    always_ff @(posedge clk) begin
        if (!resetn) begin
            y_q     <= '0;
            count_q <= '0;
        end else begin
            y_q     <= y_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/arrow_scroller.sv
// rtl/arrow_scroller.sv - four-lane scrolling arrow tracker with judgement; ARROW_HIT_JUDGE_EN enables key hits
module arrow_scroller
    import stepmania_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SPEED      = 2,
    parameter int SPAWN_Y    = 448,
    parameter int RECEPTOR_Y = 64,
    parameter int HIT_WIN    = 16,
    parameter int LANE_X0    = 240,
    parameter int LANE_PITCH = 40
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        spawn_valid,
    input  lane_t       spawn_lane,
    output logic        spawn_ready,
    input  logic [3:0]  key_press,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [3:0]  display_arrow,
    output logic [3:0]  hit_pulse,
    output logic [3:0]  miss_pulse,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam logic signed [10:0] RECEPTOR_S = 11'(RECEPTOR_Y);
    localparam logic signed [10:0] HIT_WIN_S  = 11'(HIT_WIN);
    localparam logic signed [10:0] SPEED_S    = 11'(SPEED);
    localparam logic signed [10:0] MISS_LIM_S = 11'(RECEPTOR_Y - HIT_WIN);

    logic        frame_q, frame_d;
    logic [3:0]  key_q, key_d;
    logic [3:0]  hit_pulse_q, hit_pulse_d;
    logic [3:0]  miss_pulse_q, miss_pulse_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    logic                 tick;
    logic [3:0]           key_rise;
    logic [3:0]           push;
    logic [3:0]           hit;
    logic [3:0]           miss;
    logic [3:0]           pop;
    logic [3:0]           hit_ok;
    logic [3:0]           full;
    logic [3:0]           empty;
    logic [16:0]          hit_sum;
    logic [16:0]          miss_sum;
    logic signed [10:0]   head_s [NUM_LANES];
    logic signed [10:0]   diff_s [NUM_LANES];
    arrow_y_t             head_y [NUM_LANES];
    logic [DEPTH-1:0]     valid_mask [NUM_LANES];
    arrow_y_t [DEPTH-1:0] entry_y [NUM_LANES];
    logic [10:0]          px;
    logic [10:0]          py;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        lane_fifo #(
            .DEPTH   (DEPTH),
            .SPEED   (SPEED),
            .SPAWN_Y (SPAWN_Y)
        ) u_lane_fifo (
            .clk        (Clk),
            .resetn     (Reset_n),
            .push       (push[n]),
            .pop        (pop[n]),
            .dec        (tick),
            .head_y     (head_y[n]),
            .valid_mask (valid_mask[n]),
            .entry_y    (entry_y[n]),
            .full       (full[n]),
            .empty      (empty[n])
        );
    end

    assign spawn_ready = !full[spawn_lane];
    assign hit_pulse   = hit_pulse_q;
    assign miss_pulse  = miss_pulse_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    // Per-lane spawn, hit and miss decisions; a hit takes the lane's single pop
    always_comb begin
        tick     = frame_clk & ~frame_q;
        key_rise = key_press & ~key_q;
        frame_d  = frame_clk;
        key_d    = key_press;
        for (int n = 0; n < NUM_LANES; n++) begin
            push[n]   = spawn_valid && (spawn_lane == lane_t'(n)) && !full[n];
            head_s[n] = $signed({1'b0, head_y[n]});
            diff_s[n] = head_s[n] - RECEPTOR_S;
            hit_ok[n] = (diff_s[n] >= -HIT_WIN_S) && (diff_s[n] <= HIT_WIN_S);
`ifdef ARROW_HIT_JUDGE_EN
            hit[n]    = key_rise[n] && !empty[n] && hit_ok[n];
`else
            // Keys are ignored; the key path stays referenced but is masked off
            hit[n]    = 1'b0 & key_rise[n] & hit_ok[n];
`endif
            miss[n]   = tick && !empty[n] && !hit[n] &&
                        ((head_s[n] - SPEED_S) < MISS_LIM_S);
            pop[n]    = hit[n] | miss[n];
        end
        hit_pulse_d  = hit;
        miss_pulse_d = miss;
        hit_sum      = {1'b0, hit_count_q} + {14'b0, popcount4(hit)};
        miss_sum     = {1'b0, miss_count_q} + {14'b0, popcount4(miss)};
        hit_count_d  = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
        miss_count_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end

    // Pixel hit-test against every live arrow box in every lane
    always_comb begin
        display_arrow = '0;
        px = {1'b0, DrawX};
        py = {1'b0, DrawY};
        for (int n = 0; n < NUM_LANES; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_mask[n][i] &&
                    (px >= 11'(LANE_X0 + n * LANE_PITCH)) &&
                    (px <  11'(LANE_X0 + n * LANE_PITCH + ARROW_SIZE)) &&
                    (py >= {1'b0, entry_y[n][i]}) &&
                    (py <  ({1'b0, entry_y[n][i]} + 11'(ARROW_SIZE)))) begin
                    display_arrow[n] = 1'b1;
                end
            end
        end
    end

    // Edge detectors, judgement strobes and saturating totals
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_q      <= 1'b0;
            key_q        <= '0;
            hit_pulse_q  <= '0;
            miss_pulse_q <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            frame_q      <= frame_d;
            key_q        <= key_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_arrow_scroller.sv
// tb/tb_arrow_scroller.sv - scoreboard bench for arrow_scroller
module tb_arrow_scroller;

    typedef struct packed {
        logic [3:0] hit;
        logic [3:0] miss;
    } judge_t;

    logic        clk;
    logic        resetn;
    logic        frame_clk;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic        spawn_ready;
    logic [3:0]  key_press;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [3:0]  display_arrow;
    logic [3:0]  hit_pulse;
    logic [3:0]  miss_pulse;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int     n_checks = 0;
    int     n_pass   = 0;
    judge_t exp_q[$];

    arrow_scroller dut (
        .Clk           (clk),
        .Reset_n       (resetn),
        .frame_clk     (frame_clk),
        .spawn_valid   (spawn_valid),
        .spawn_lane    (spawn_lane),
        .spawn_ready   (spawn_ready),
        .key_press     (key_press),
        .DrawX         (draw_x),
        .DrawY         (draw_y),
        .display_arrow (display_arrow),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Every judgement strobe must match the next expectation in order
    always @(negedge clk) begin
        if (resetn && (hit_pulse != 4'b0 || miss_pulse != 4'b0)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {24'b0, hit_pulse, miss_pulse}, 32'h0);
            end else begin
                judge_t e;
                e = exp_q.pop_front();
                check("sb_pulse", {24'b0, hit_pulse, miss_pulse}, {24'b0, e});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetn      = 1'b0;
        frame_clk   = 1'b0;
        spawn_valid = 1'b0;
        key_press   = 4'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic spawn(input logic [1:0] lane);
        @(negedge clk);
        spawn_valid = 1'b1;
        spawn_lane  = lane;
        @(negedge clk);
        spawn_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_clk = 1'b1;
            @(negedge clk);
            frame_clk = 1'b0;
        end
    endtask

    task automatic key_rise(input int lane, input logic with_tick);
        @(negedge clk);
        key_press[lane] = 1'b1;
        frame_clk       = with_tick;
        @(negedge clk);
        key_press[lane] = 1'b0;
        frame_clk       = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input string tag, input logic [3:0] exp);
        draw_x = 10'(x);
        draw_y = 10'(y);
        #1;
        check(tag, {28'b0, display_arrow}, {28'b0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; frame_clk = 1'b0; spawn_valid = 1'b0; spawn_lane = 2'd0;
        key_press = 4'b0; draw_x = 10'd0; draw_y = 10'd0;

        // Reset state
        do_reset();
        #1;
        check("rst_ready", {31'b0, spawn_ready}, 32'd1);
        check("rst_hitc", {16'b0, hit_count}, 32'd0);
        check("rst_missc", {16'b0, miss_count}, 32'd0);
        check("rst_pulses", {24'b0, hit_pulse, miss_pulse}, 32'd0);
        probe(240, 448, "rst_display", 4'b0000);

        // Lane 2 arrow scrolls to Y=48, then misses on the next tick
        spawn(2'd2);
        ticks(200);
        probe(320, 48, "a_disp_48", 4'b0100);
        probe(320, 47, "a_disp_47", 4'b0000);
        check("a_no_miss", {16'b0, miss_count}, 32'd0);
        exp_q.push_back('{hit: 4'b0000, miss: 4'b0100});
        ticks(1);
        @(negedge clk);
        check("a_missc", {16'b0, miss_count}, 32'd1);
        probe(320, 46, "a_gone", 4'b0000);

        // Lane 0 at Y=80 is inside the window
        do_reset();
        spawn(2'd0);
        ticks(184);
        probe(240, 80, "b_disp_80", 4'b0001);
`ifdef ARROW_HIT_JUDGE_EN
        exp_q.push_back('{hit: 4'b0001, miss: 4'b0000});
        key_rise(0, 1'b0);
        @(negedge clk);
        check("b_hitc", {16'b0, hit_count}, 32'd1);
        probe(240, 80, "b_popped", 4'b0000);
`else
        key_rise(0, 1'b0);
        @(negedge clk);
        check("b_hitc", {16'b0, hit_count}, 32'd0);
        probe(240, 80, "b_popped", 4'b0001);
`endif

        // Lane 0 at Y=82 is just outside the window
        do_reset();
        spawn(2'd0);
        ticks(183);
        key_rise(0, 1'b0);
        @(negedge clk);
        check("b2_hitc", {16'b0, hit_count}, 32'd0);
        probe(240, 82, "b2_stays", 4'b0001);

        // Fill lane 1, ninth request dropped, other lanes unaffected
        do_reset();
        @(negedge clk);
        spawn_valid = 1'b1;
        spawn_lane  = 2'd1;
        repeat (8) @(negedge clk);
        spawn_valid = 1'b0;
        #1;
        check("c_full_ready", {31'b0, spawn_ready}, 32'd0);
        spawn_lane = 2'd3;
        #1;
        check("c_lane3_ready", {31'b0, spawn_ready}, 32'd1);
        spawn(2'd1);
        for (int i = 0; i < 8; i++) exp_q.push_back('{hit: 4'b0000, miss: 4'b0010});
        ticks(212);
        @(negedge clk);
        check("c_missc", {16'b0, miss_count}, 32'd8);

        // Key rise coinciding with a tick at Y=48
        do_reset();
        spawn(2'd3);
        ticks(200);
`ifdef ARROW_HIT_JUDGE_EN
        exp_q.push_back('{hit: 4'b1000, miss: 4'b0000});
        key_rise(3, 1'b1);
        @(negedge clk);
        check("d_hitc", {16'b0, hit_count}, 32'd1);
        check("d_missc", {16'b0, miss_count}, 32'd0);
`else
        exp_q.push_back('{hit: 4'b0000, miss: 4'b1000});
        key_rise(3, 1'b1);
        @(negedge clk);
        check("d_hitc", {16'b0, hit_count}, 32'd0);
        check("d_missc", {16'b0, miss_count}, 32'd1);
`endif

        // Pixel box edges for a lane 1 arrow at Y=100
        do_reset();
        spawn(2'd1);
        ticks(174);
        probe(280, 100, "e_inside", 4'b0010);
        probe(311, 131, "e_corner", 4'b0010);
        probe(312, 100, "e_right", 4'b0000);
        probe(280, 132, "e_bottom", 4'b0000);
        probe(279, 100, "e_left", 4'b0000);

        // Mid-operation reset discards live arrows silently
        do_reset();
        spawn(2'd0); spawn(2'd1); spawn(2'd2); spawn(2'd3); spawn(2'd0);
        ticks(10);
        probe(240, 428, "f_pre", 4'b0001);
        do_reset();
        #1;
        spawn_lane = 2'd0;
        #1;
        check("f_ready", {31'b0, spawn_ready}, 32'd1);
        for (int l = 0; l < 4; l++) probe(240 + l * 40, 428, "f_disp", 4'b0000);
        ticks(210);
        @(negedge clk);
        check("f_missc", {16'b0, miss_count}, 32'd0);
        check("f_hitc", {16'b0, hit_count}, 32'd0);

        check("sb_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
